// File: rtl/sha_1_padder.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks, appends the
// 0x80 marker, zero fill and 64-bit big-endian bit length, and hands each block
// to the hash core, pacing itself on the core's Ready pulse.
module sha_1_padder #(
    parameter int unsigned CNT_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic [511:0] blk_data,
    output logic [63:0]  blk_index,
    output logic         blk_enable,
    input  logic         blk_ready,
    output logic         msg_done,
    output logic         busy
);

    typedef enum logic [1:0] {StFill, StSend, StWait} state_t;

    state_t             r_state;
    logic [511:0]       r_buf;
    logic [6:0]         r_ptr;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [63:0]        r_blk_index;
    logic               r_pend_final;
    logic               r_pend_extra;
    logic               r_pend_80;

    state_t             w_state_nxt;
    logic [511:0]       w_buf_nxt;
    logic [6:0]         w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [63:0]        w_idx_nxt;
    logic               w_final_nxt;
    logic               w_extra_nxt;
    logic               w_p80_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [63:0]        w_len_cur;
    logic [63:0]        w_len_inc;

    // Byte j of a block sits big-endian inside word j/4; word 0 is the LSBs.
    function automatic logic [511:0] f_put_byte(input logic [511:0] blk,
                                                input logic [6:0]   idx,
                                                input logic [7:0]   val);
        logic [511:0] res;
        logic [8:0]   off;
        res = blk;
        off = {idx[5:2], 5'd0} + 9'd24 - {4'd0, idx[1:0], 3'd0};
        if (idx < 7'd64) begin
            res[off+:8] = val;
        end
        return res;
    endfunction

    // Bit length occupies bytes 56..63, i.e. word 14 (high half) and word 15.
    function automatic logic [511:0] f_put_len(input logic [511:0] blk,
                                               input logic [63:0]  len);
        logic [511:0] res;
        res = blk;
        res[479:448] = len[63:32];
        res[511:480] = len[31:0];
        return res;
    endfunction

    assign w_cnt_inc  = r_byte_cnt + CNT_W'(1);
    assign w_len_cur  = 64'({r_byte_cnt, 3'b000});
    assign w_len_inc  = 64'({w_cnt_inc, 3'b000});
    assign blk_data   = r_buf;
    assign blk_index  = r_blk_index;
    assign busy       = (r_state != StFill) || (r_ptr != 7'd0) || (r_byte_cnt != '0);

    // Next-state, buffer update and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_byte_cnt;
        w_idx_nxt   = r_blk_index;
        w_final_nxt = r_pend_final;
        w_extra_nxt = r_pend_extra;
        w_p80_nxt   = r_pend_80;
        in_ready    = 1'b0;
        blk_enable  = 1'b0;
        msg_done    = 1'b0;
        unique case (r_state)
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last && in_empty) begin
                        // Zero-length message: marker only, length field stays 0.
                        w_buf_nxt   = f_put_byte(512'd0, 7'd0, 8'h80);
                        w_final_nxt = 1'b1;
                        w_state_nxt = StSend;
                    end else begin
                        w_buf_nxt = f_put_byte(r_buf, r_ptr, in_data);
                        w_ptr_nxt = r_ptr + 7'd1;
                        w_cnt_nxt = w_cnt_inc;
                        if (in_last) begin
                            w_state_nxt = StSend;
                            if (w_ptr_nxt <= 7'd55) begin
                                w_buf_nxt   = f_put_len(f_put_byte(w_buf_nxt, w_ptr_nxt, 8'h80),
                                                        w_len_inc);
                                w_final_nxt = 1'b1;
                            end else if (w_ptr_nxt <= 7'd63) begin
                                w_buf_nxt   = f_put_byte(w_buf_nxt, w_ptr_nxt, 8'h80);
                                w_extra_nxt = 1'b1;
                            end else begin
                                // Block exactly full: marker moves to the extra block.
                                w_extra_nxt = 1'b1;
                                w_p80_nxt   = 1'b1;
                            end
                        end else if (w_ptr_nxt == 7'd64) begin
                            w_state_nxt = StSend;
                        end
                    end
                end
            end
            StSend: begin
                blk_enable  = 1'b1;
                w_state_nxt = StWait;
            end
            StWait: begin
                if (blk_ready) begin
                    w_idx_nxt = r_blk_index + 64'd1;
                    if (r_pend_extra) begin
                        w_buf_nxt   = f_put_len(f_put_byte(512'd0, 7'd0,
                                                           r_pend_80 ? 8'h80 : 8'h00),
                                                w_len_cur);
                        w_extra_nxt = 1'b0;
                        w_p80_nxt   = 1'b0;
                        w_final_nxt = 1'b1;
                        w_state_nxt = StSend;
                    end else if (r_pend_final) begin
                        msg_done    = 1'b1;
                        w_buf_nxt   = 512'd0;
                        w_ptr_nxt   = 7'd0;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = 64'd0;
                        w_final_nxt = 1'b0;
                        w_state_nxt = StFill;
                    end else begin
                        w_buf_nxt   = 512'd0;
                        w_ptr_nxt   = 7'd0;
                        w_state_nxt = StFill;
                    end
                end
            end
            default: begin
                w_state_nxt = StFill;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StFill;
            r_buf        <= 512'd0;
            r_ptr        <= 7'd0;
            r_byte_cnt   <= '0;
            r_blk_index  <= 64'd0;
            r_pend_final <= 1'b0;
            r_pend_extra <= 1'b0;
            r_pend_80    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_ptr        <= w_ptr_nxt;
            r_byte_cnt   <= w_cnt_nxt;
            r_blk_index  <= w_idx_nxt;
            r_pend_final <= w_final_nxt;
            r_pend_extra <= w_extra_nxt;
            r_pend_80    <= w_p80_nxt;
        end
    end

endmodule
